// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer: control codes, FSM states,
// cursor operations and the default fill character.
package text_console_pkg;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_ESC = 8'h1B;

    localparam logic [7:0] BLANK_DEFAULT = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC_COL,
        ST_ESC_ROW,
        ST_CLR_ROW,
        ST_CLR_ALL
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_INC,
        CUR_DEC,
        CUR_NEWLINE,
        CUR_CR,
        CUR_SET,
        CUR_HOME
    } cur_op_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte-stream input handshake plus text-RAM write port of the console.
interface text_console_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [12:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;

    // Byte source / RAM observer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, ram_waddr, ram_wdata, ram_wren
    );

    // Console side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_waddr, ram_wdata, ram_wren
    );
endinterface

// File: rtl/text_console_cursor_addr.sv
// Cursor column/row plus the matching linear text-RAM address. The row base
// advances by NUM_COLS per newline so no multiplier sits on the common path.
module text_console_cursor_addr
    import text_console_pkg::*;
#(
    parameter int NUM_COLS = 40,
    parameter int NUM_ROWS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  cur_op_t     op,
    input  logic [5:0]  set_col,
    input  logic [3:0]  set_row,
    output logic [5:0]  col,
    output logic [3:0]  row,
    output logic [12:0] addr,
    output logic [12:0] next_base,
    output logic        last_col
);
    logic [12:0] base;
    logic        last_row;

    assign addr      = base + 13'(col);
    assign last_col  = (col == 6'(NUM_COLS - 1));
    assign last_row  = (row == 4'(NUM_ROWS - 1));
    assign next_base = last_row ? 13'd0 : base + 13'(NUM_COLS);

    // Apply one cursor operation per cycle; rows wrap, the screen never scrolls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else begin
            case (op)
                CUR_INC: begin
                    if (last_col) begin
                        col  <= '0;
                        row  <= last_row ? 4'd0 : row + 4'd1;
                        base <= next_base;
                    end else begin
                        col <= col + 6'd1;
                    end
                end
                CUR_DEC: col <= col - 6'd1;
                CUR_NEWLINE: begin
                    col  <= '0;
                    row  <= last_row ? 4'd0 : row + 4'd1;
                    base <= next_base;
                end
                CUR_CR: col <= '0;
                CUR_SET: begin
                    col  <= set_col;
                    row  <= set_row;
                    base <= 13'(set_row) * 13'(NUM_COLS);
                end
                CUR_HOME: begin
                    col  <= '0;
                    row  <= '0;
                    base <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/text_console.sv
// Console writer: decodes a byte stream into text-RAM writes, tracks the
// cursor and runs row / full-screen clear bursts.
module text_console
    import text_console_pkg::*;
#(
    parameter int         NUM_COLS       = 40,
    parameter int         NUM_ROWS       = 15,
    parameter logic [7:0] BLANK          = BLANK_DEFAULT,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    text_console_if.slave bus,
    output logic [5:0]   cursor_col,
    output logic [3:0]   cursor_row,
    output logic         busy
);
    localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

    state_t      state, state_nx;
    logic        started;
    cur_op_t     cur_op;
    logic        accept, in_clear;
    logic        wr_nx;
    logic [12:0] waddr_nx;
    logic [7:0]  wdata_nx;
    logic        clr_start_row, clr_start_all;
    logic [12:0] clr_addr;
    logic [9:0]  clr_rem;
    logic [5:0]  esc_col, col_clamp;
    logic [3:0]  row_clamp;
    logic [12:0] cur_addr, next_base;
    logic        last_col;

    assign accept    = bus.in_valid && bus.in_ready;
    assign in_clear  = (state == ST_CLR_ROW) || (state == ST_CLR_ALL);
    assign col_clamp = (bus.in_data >= 8'(NUM_COLS)) ? 6'(NUM_COLS - 1) : bus.in_data[5:0];
    assign row_clamp = (bus.in_data >= 8'(NUM_ROWS)) ? 4'(NUM_ROWS - 1) : bus.in_data[3:0];

    text_console_cursor_addr #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)) u_cursor (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (cur_op),
        .set_col   (esc_col),
        .set_row   (row_clamp),
        .col       (cursor_col),
        .row       (cursor_row),
        .addr      (cur_addr),
        .next_base (next_base),
        .last_col  (last_col)
    );

    // State register; 'started' holds everything idle for the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
        end
    end

    // Next state, cursor operation and the next write-port value.
    always_comb begin
        state_nx      = state;
        cur_op        = CUR_NONE;
        wr_nx         = 1'b0;
        waddr_nx      = cur_addr;
        wdata_nx      = bus.in_data;
        clr_start_row = 1'b0;
        clr_start_all = 1'b0;
        if (!started) begin
            if (CLEAR_ON_RESET) begin
                state_nx      = ST_CLR_ALL;
                clr_start_all = 1'b1;
                wr_nx         = 1'b1;
                waddr_nx      = '0;
                wdata_nx      = BLANK;
            end
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    if (is_printable(bus.in_data)) begin
                        wr_nx  = 1'b1;
                        cur_op = CUR_INC;
                        if (last_col) begin
                            state_nx      = ST_CLR_ROW;
                            clr_start_row = 1'b1;
                        end
                    end else begin
                        case (bus.in_data)
                            CH_LF: begin
                                cur_op        = CUR_NEWLINE;
                                state_nx      = ST_CLR_ROW;
                                clr_start_row = 1'b1;
                            end
                            CH_CR: cur_op = CUR_CR;
                            CH_BS: if (cursor_col != 6'd0) begin
                                cur_op   = CUR_DEC;
                                wr_nx    = 1'b1;
                                waddr_nx = cur_addr - 13'd1;
                                wdata_nx = BLANK;
                            end
                            CH_FF: begin
                                cur_op        = CUR_HOME;
                                state_nx      = ST_CLR_ALL;
                                clr_start_all = 1'b1;
                                wr_nx         = 1'b1;
                                waddr_nx      = '0;
                                wdata_nx      = BLANK;
                            end
                            CH_ESC: state_nx = ST_ESC_COL;
                            default: ;
                        endcase
                    end
                end
                ST_ESC_COL: if (accept) state_nx = ST_ESC_ROW;
                ST_ESC_ROW: if (accept) begin
                    cur_op   = CUR_SET;
                    state_nx = ST_IDLE;
                end
                ST_CLR_ROW, ST_CLR_ALL: begin
                    if (clr_rem != 10'd0) begin
                        wr_nx    = 1'b1;
                        waddr_nx = clr_addr;
                        wdata_nx = BLANK;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs follow the state directly.
    always_comb begin
        bus.in_ready = started && ((state == ST_IDLE) || (state == ST_ESC_COL) ||
                                   (state == ST_ESC_ROW));
        busy         = in_clear;
    end

    // Registered write port, clear-burst down-counter and ESC column latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_wren  <= 1'b0;
            bus.ram_waddr <= '0;
            bus.ram_wdata <= '0;
            clr_addr      <= '0;
            clr_rem       <= '0;
            esc_col       <= '0;
        end else begin
            bus.ram_wren  <= wr_nx;
            bus.ram_waddr <= waddr_nx;
            bus.ram_wdata <= wdata_nx;
            // A full clear issues cell 0 on its entry edge; a row clear starts one edge later.
            if (clr_start_all) begin
                clr_addr <= 13'd1;
                clr_rem  <= 10'(NUM_CELLS - 1);
            end else if (clr_start_row) begin
                clr_addr <= next_base;
                clr_rem  <= 10'(NUM_COLS);
            end else if (in_clear && clr_rem != 10'd0) begin
                clr_addr <= clr_addr + 13'd1;
                clr_rem  <= clr_rem - 10'd1;
            end
            if (started && state == ST_ESC_COL && accept) begin
                esc_col <= col_clamp;
            end
        end
    end
endmodule

// File: tb/tb_text_console.sv
// Randomized and directed bench for text_console with a cursor/screen
// reference model and a write-port scoreboard.
module tb_text_console;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] cursor_col;
    logic [3:0] cursor_row;
    logic       busy;

    text_console_if tif();

    text_console dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (tif),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: cursor position, escape progress, queue of expected writes.
    int m_col = 0, m_row = 0, m_mode = 0, m_esc_col = 0;
    int exp_q[$];

    function automatic void push_wr(input int a, input int d);
        exp_q.push_back((a << 8) | d);
    endfunction

    function automatic void clear_row(input int r);
        for (int c = 0; c < 40; c++) push_wr(r * 40 + c, 32'h20);
    endfunction

    function automatic void clear_all();
        for (int a = 0; a < 600; a++) push_wr(a, 32'h20);
    endfunction

    function automatic void model_accept(input int b);
        if (m_mode == 1) begin
            m_esc_col = (b > 39) ? 39 : b;
            m_mode = 2;
        end else if (m_mode == 2) begin
            m_row = (b > 14) ? 14 : b;
            m_col = m_esc_col;
            m_mode = 0;
        end else if (b >= 32 && b <= 126) begin
            push_wr(m_row * 40 + m_col, b);
            m_col++;
            if (m_col == 40) begin
                m_col = 0;
                m_row = (m_row + 1) % 15;
                clear_row(m_row);
            end
        end else if (b == 10) begin
            m_col = 0;
            m_row = (m_row + 1) % 15;
            clear_row(m_row);
        end else if (b == 13) begin
            m_col = 0;
        end else if (b == 8) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row * 40 + m_col, 32'h20);
            end
        end else if (b == 12) begin
            m_col = 0;
            m_row = 0;
            clear_all();
        end else if (b == 27) begin
            m_mode = 1;
        end
    endfunction

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (tif.ram_wren) begin
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'(tif.ram_waddr), 32'hFFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(tif.ram_waddr), 32'(e >> 8));
                chk("wr_data", 32'(tif.ram_wdata), 32'(e & 255));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (!tif.in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            chk("ready_timeout", 32'(tif.in_ready), 32'd1);
        end else begin
            tif.in_valid = 1'b1;
            tif.in_data  = b;
            model_accept(int'(b));
            @(posedge clk);
            #1;
            tif.in_valid = 1'b0;
            chk("cur_col", 32'(cursor_col), 32'(m_col));
            chk("cur_row", 32'(cursor_row), 32'(m_row));
        end
    endtask

    // Called right after rst_n rises at a falling edge: burst must start next cycle.
    task automatic check_boot_clear();
        int lat = 0;
        int cnt = 0;
        while (!tif.ram_wren && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("boot_latency", 32'(lat), 32'd1);
        chk("boot_busy", 32'(busy), 32'd1);
        while (tif.ram_wren && cnt < 1000) begin
            chk("boot_ready_low", 32'(tif.in_ready), 32'd0);
            @(negedge clk);
            cnt++;
        end
        chk("boot_burst_len", 32'(cnt), 32'd600);
        chk("boot_ready", 32'(tif.in_ready), 32'd1);
        chk("boot_col", 32'(cursor_col), 32'd0);
        chk("boot_row", 32'(cursor_row), 32'd0);
    endtask

    initial begin
        tif.in_valid = 1'b0;
        tif.in_data  = 8'h00;
        #23;
        chk("rst_ready", 32'(tif.in_ready), 32'd0);
        chk("rst_wren", 32'(tif.ram_wren), 32'd0);
        chk("rst_waddr", 32'(tif.ram_waddr), 32'd0);
        chk("rst_wdata", 32'(tif.ram_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        clear_all();
        check_boot_clear();

        // "WAV" on consecutive cycles.
        send_byte(8'h57);
        send_byte(8'h41);
        send_byte(8'h56);
        chk("wav_col", 32'(cursor_col), 32'd3);

        // 41 printables from (0,0): wrap, row-1 clear, 41st at address 40.
        send_byte(8'h0D);
        for (int i = 0; i < 40; i++) send_byte(8'(8'h30 + (i % 40)));
        begin
            int low = 0;
            @(negedge clk);
            while (!tif.in_ready && low < 200) begin
                low++;
                @(negedge clk);
            end
            chk("wrap_ready_low", 32'(low), 32'd41);
        end
        send_byte(8'h5A);
        chk("wrap_cursor", 32'({cursor_row, cursor_col}), 32'({4'd1, 6'd1}));

        // ESC positioning with clamping, then BS at the new spot.
        send_byte(8'h1B);
        send_byte(8'd5);
        send_byte(8'd20);
        chk("esc_col", 32'(cursor_col), 32'd5);
        chk("esc_row", 32'(cursor_row), 32'd14);
        send_byte(8'h41);
        send_byte(8'h08);
        chk("bs_col", 32'(cursor_col), 32'd5);

        // LF at the bottom row wraps to row 0; FF and ignored codes.
        send_byte(8'h0A);
        chk("lf_wrap_row", 32'(cursor_row), 32'd0);
        send_byte(8'h0C);
        send_byte(8'h7F);
        send_byte(8'h01);
        chk("ff_cursor", 32'({cursor_row, cursor_col}), 32'd0);

        // Randomized stream.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 94) b = 8'h1B;
            else if (r < 95) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_byte(b);
        end

        // Reset in the middle of a full clear.
        send_byte(8'h0C);
        repeat (100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wren", 32'(tif.ram_wren), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(tif.in_ready), 32'd0);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        m_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_all();
        check_boot_clear();

        send_byte(8'h4F);
        send_byte(8'h4B);
        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
        end
        repeat (2) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
